fir_coef_loader: RTL and testbench

Register-bus master that loads a coefficient set into the multi-channel FIR parameter RAMs and sets its control word without glitching live audio. Sits on the `clk_2` register bus in front of the FIR bank.
- Forces bypass while coefficients change, streams coefficient words in, and reads them back to verify with a checksum.
- Commits the requested control word only if verification passes.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/reg_bus_master.sv | 65 ++++++
 rtl/fir_coef_loader.sv | 213 +++++++++++++++++++++
 tb/tb_fir_coef_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR coefficient loader.
//   - CFG_ADDR    : register-bus address of the FIR control word.
//   - field offsets of the 21-bit control word
//     {bypass, pcm_out_shift[3:0], tap_len[7:0], down_sample[7:0]}.
//   - state_e     : loader FSM states.
//   - clamp_words : limits a requested word count to the supported maximum.
//   - bypass_word : control word with the bypass bit forced on.
package fir_pkg;

  localparam logic [7:0] CFG_ADDR   = 8'hff;
  localparam int         CFG_W      = 21;
  localparam int         BYPASS_BIT = 20;
  localparam int         SHIFT_MSB  = 19;
  localparam int         SHIFT_LSB  = 16;
  localparam int         TAP_MSB    = 15;
  localparam int         TAP_LSB    = 8;
  localparam int         DS_MSB     = 7;
  localparam int         DS_LSB     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BYP_WR,
    ST_COEF_WR,
    ST_RD_BACK,
    ST_CHECK,
    ST_CFG_WR,
    ST_FAIL
  } state_e;

  function automatic logic [7:0] clamp_words(input logic [7:0] n, input int unsigned max_w);
    logic [31:0] max_v;
    max_v = 32'(max_w);
    if ({24'd0, n} > max_v) return max_v[7:0];
    return n;
  endfunction

  // Same tap/shift/decimation settings as the requested word, bypass on.
  function automatic logic [31:0] bypass_word(input logic [CFG_W-1:0] cfg);
    return {11'd0, 1'b1, cfg[SHIFT_MSB:SHIFT_LSB], cfg[TAP_MSB:TAP_LSB], cfg[DS_MSB:DS_LSB]};
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// reg_bus_master: single-outstanding transaction engine for the strobe/ready
// register bus.
//   clk_2, rst_n          : clock, asynchronous active-low reset
//   req_i/req_wr_i        : request from the FSM (write when req_wr_i=1)
//   req_addr_i/req_wdata_i: address and write data of the request
//   accept_o              : request taken this cycle (strobe rises next cycle)
//   ack_o                 : transaction completes this cycle (reg_ready seen)
//   busy_o                : a strobe is currently held
//   rdata_o               : read data, valid while ack_o is high
//   reg_*                 : register-bus pins
// A new request may be accepted in the same cycle the previous one is
// acknowledged, so back-to-back transactions take two cycles each.
module reg_bus_master (
  input  logic        clk_2,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [7:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        accept_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [7:0]  reg_addr_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [31:0] reg_writedata_o,
  input  logic [31:0] reg_readdata_i,
  input  logic        reg_ready_i
);

  logic        wr_q;
  logic        rd_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;

  assign busy_o   = wr_q | rd_q;
  assign ack_o    = busy_o & reg_ready_i;
  assign accept_o = req_i & (~busy_o | ack_o);
  assign rdata_o  = reg_readdata_i;

  assign reg_wr_o        = wr_q;
  assign reg_rd_o        = rd_q;
  assign reg_addr_o      = addr_q;
  assign reg_writedata_o = wdata_q;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
    end else if (accept_o) begin
      // wr and rd are mutually exclusive by construction.
      wr_q    <= req_wr_i;
      rd_q    <= ~req_wr_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end else if (ack_o) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: loads a coefficient set into the FIR parameter RAMs over
// the register bus with bypass forced on, reads it back, and commits the
// requested control word only if the read-back checksum matches.
//   clk_2, rst_n              : clock, asynchronous active-low reset
//   start, n_words, cfg_word  : load request (sampled when accepted in IDLE)
//   coef_valid/ready/data     : coefficient stream
//   reg_addr/wr/rd/writedata  : register-bus master outputs
//   reg_readdata, reg_ready   : register-bus slave responses
//   busy, done, err           : status (done is a one-cycle pulse, err sticky)
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int MAX_WORDS = 255
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       n_words,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic             coef_valid,
  output logic             coef_ready,
  input  logic [31:0]      coef_data,
  output logic [7:0]       reg_addr,
  output logic             reg_wr,
  output logic             reg_rd,
  output logic [31:0]      reg_writedata,
  input  logic [31:0]      reg_readdata,
  input  logic             reg_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [7:0]       n_q, n_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [7:0]       idx_q, idx_d;      // address of the next transaction to issue
  logic [7:0]       cnt_q, cnt_d;      // read-backs completed
  logic             rd_all_q, rd_all_d;
  logic [31:0]      wr_sum_q, wr_sum_d;
  logic [31:0]      rd_sum_q, rd_sum_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             req;
  logic             req_wr;
  logic [7:0]       req_addr;
  logic [31:0]      req_wdata;
  logic             mst_accept;
  logic             mst_ack;
  logic             mst_busy;
  logic [31:0]      mst_rdata;
  logic [7:0]       last_idx;
  logic             coef_ready_c;

  assign last_idx   = n_q - 8'd1;
  assign coef_ready = coef_ready_c;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

  reg_bus_master u_bus (
    .clk_2           (clk_2),
    .rst_n           (rst_n),
    .req_i           (req),
    .req_wr_i        (req_wr),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .accept_o        (mst_accept),
    .ack_o           (mst_ack),
    .busy_o          (mst_busy),
    .rdata_o         (mst_rdata),
    .reg_addr_o      (reg_addr),
    .reg_wr_o        (reg_wr),
    .reg_rd_o        (reg_rd),
    .reg_writedata_o (reg_writedata),
    .reg_readdata_i  (reg_readdata),
    .reg_ready_i     (reg_ready)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cfg_d        = cfg_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rd_all_d     = rd_all_q;
    wr_sum_d     = wr_sum_q;
    rd_sum_d     = rd_sum_q;
    err_d        = err_q;
    done_d       = 1'b0;
    req          = 1'b0;
    req_wr       = 1'b0;
    req_addr     = CFG_ADDR;
    req_wdata    = 32'd0;
    coef_ready_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The done cycle already shows IDLE; a start coinciding with it is dropped.
        if (start && !done_q) begin
          state_d  = ST_BYP_WR;
          n_d      = clamp_words(n_words, MAX_WORDS);
          cfg_d    = cfg_word;
          idx_d    = 8'd0;
          cnt_d    = 8'd0;
          rd_all_d = 1'b0;
          wr_sum_d = 32'd0;
          rd_sum_d = 32'd0;
          err_d    = 1'b0;
        end
      end

      ST_BYP_WR: begin
        req       = ~mst_busy;
        req_wr    = 1'b1;
        req_wdata = bypass_word(cfg_q);
        if (mst_ack) state_d = (n_q == 8'd0) ? ST_CFG_WR : ST_COEF_WR;
      end

      ST_COEF_WR: begin
        // One word in flight at a time: a word is taken only when the bus is
        // idle, and that acceptance is itself the bus request.
        coef_ready_c = ~mst_busy;
        req          = coef_valid & ~mst_busy;
        req_wr       = 1'b1;
        req_addr     = idx_q;
        req_wdata    = coef_data;
        if (mst_accept) wr_sum_d = wr_sum_q + coef_data;
        if (mst_ack) begin
          if (idx_q == last_idx) begin
            idx_d   = 8'd0;
            state_d = ST_RD_BACK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      ST_RD_BACK: begin
        // Reads are issued back-to-back; issue and completion are tracked apart.
        req      = ~rd_all_q;
        req_addr = idx_q;
        if (mst_accept) begin
          if (idx_q == last_idx) rd_all_d = 1'b1;
          else                   idx_d    = idx_q + 8'd1;
        end
        if (mst_ack) begin
          rd_sum_d = rd_sum_q + mst_rdata;
          if (cnt_q == last_idx) state_d = ST_CHECK;
          else                   cnt_d   = cnt_q + 8'd1;
        end
      end

      ST_CHECK: begin
        // The commit write is launched from here so the check costs one cycle.
        if (wr_sum_q == rd_sum_q) begin
          req       = 1'b1;
          req_wr    = 1'b1;
          req_wdata = {11'd0, cfg_q};
          if (mst_accept) state_d = ST_CFG_WR;
        end else begin
          state_d = ST_FAIL;
          err_d   = 1'b1;
        end
      end

      ST_CFG_WR: begin
        req       = ~mst_busy;
        req_wr    = 1'b1;
        req_wdata = {11'd0, cfg_q};
        if (mst_ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_FAIL: begin
        // Bypass stays set in the FIR: the control word is left as written.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_q      <= 8'd0;
      cfg_q    <= '0;
      idx_q    <= 8'd0;
      cnt_q    <= 8'd0;
      rd_all_q <= 1'b0;
      wr_sum_q <= 32'd0;
      rd_sum_q <= 32'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cfg_q    <= cfg_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rd_all_q <= rd_all_d;
      wr_sum_q <= wr_sum_d;
      rd_sum_q <= rd_sum_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: table-driven and randomized checks of fir_coef_loader
// against a transaction-list reference model and a toggling-ready bus slave.
module tb_fir_coef_loader;

  logic        clk_2 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n_words = 8'd0;
  logic [20:0] cfg_word = 21'd0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [31:0] coef_data = 32'd0;
  logic [7:0]  reg_addr;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_writedata;
  logic [31:0] reg_readdata;
  logic        reg_ready;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk_2 = ~clk_2;

  fir_coef_loader dut (
    .clk_2         (clk_2),
    .rst_n         (rst_n),
    .start         (start),
    .n_words       (n_words),
    .cfg_word      (cfg_word),
    .coef_valid    (coef_valid),
    .coef_ready    (coef_ready),
    .coef_data     (coef_data),
    .reg_addr      (reg_addr),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_writedata (reg_writedata),
    .reg_readdata  (reg_readdata),
    .reg_ready     (reg_ready),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // ---------------- bus slave: ready toggles while a strobe is held -------
  logic [31:0] mem [256];
  logic        ready_q = 1'b0;
  int          corrupt_addr = -1;

  always @(posedge clk_2) begin
    ready_q <= (reg_wr || reg_rd) ? ~ready_q : 1'b0;
    if (reg_wr && ready_q) mem[reg_addr] <= reg_writedata;
  end
  assign reg_ready    = ready_q;
  assign reg_readdata = mem[reg_addr] + ((corrupt_addr == int'(reg_addr)) ? 32'd1 : 32'd0);

  // ---------------- bus monitor --------------------------------------------
  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t got_q[$];
  int   both_hi = 0;

  always @(posedge clk_2) begin
    if (reg_wr && reg_rd) both_hi <= both_hi + 1;
    if ((reg_wr || reg_rd) && reg_ready)
      got_q.push_back(txn_t'{wr: reg_wr, addr: reg_addr, data: (reg_wr ? reg_writedata : reg_readdata)});
  end

  // ---------------- checking helpers ----------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model -----------------------------------------
  logic [31:0] words_q[$];
  txn_t        exp_q[$];

  // Expected bus transactions of a load, from the behavioural rules:
  // bypass write, coefficient writes, read-backs, then commit only if sums agree.
  task automatic model(input int n, input logic [20:0] cfg, input int caddr, output bit exp_err);
    logic [31:0] wsum;
    logic [31:0] rsum;
    logic [31:0] d;
    wsum = 32'd0;
    rsum = 32'd0;
    exp_q.delete();
    exp_q.push_back(txn_t'{wr: 1'b1, addr: 8'hff, data: {11'd0, 1'b1, cfg[19:0]}});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(txn_t'{wr: 1'b1, addr: 8'(i), data: words_q[i]});
      wsum += words_q[i];
    end
    for (int i = 0; i < n; i++) begin
      d = words_q[i] + ((i == caddr) ? 32'd1 : 32'd0);
      exp_q.push_back(txn_t'{wr: 1'b0, addr: 8'(i), data: d});
      rsum += d;
    end
    exp_err = (wsum != rsum);
    if (!exp_err) exp_q.push_back(txn_t'{wr: 1'b1, addr: 8'hff, data: {11'd0, cfg}});
  endtask

  function automatic int model_latency(input int n, input int gap_after, input int gap_len);
    if (n == 0) return 6;
    return 7 + 5 * n + ((gap_after >= 0 && gap_after < n) ? gap_len : 0);
  endfunction

  // ---------------- load driver ---------------------------------------------
  // Drives one load; c counts clock edges after the edge that sampled start.
  task automatic run_load(input int n, input logic [20:0] cfg, input int gap_after,
                          input int gap_len, input int busy_at, input int abort_after,
                          input bit start_on_done, output int lat, output bit aborted);
    int acc;
    int gap_cnt;
    int c;
    bit gap_wr;
    acc = 0; gap_cnt = 0; c = 0; gap_wr = 0; lat = -1; aborted = 0;
    got_q.delete();
    @(negedge clk_2);
    start = 1'b1; n_words = 8'(n); cfg_word = cfg;
    @(negedge clk_2);
    start = 1'b0;
    while (c < 4000) begin
      if (done) lat = c;
      if (!busy) begin
        if (start_on_done && done) begin
          start = 1'b1;
          @(negedge clk_2);
          start = 1'b0;
          chk("start_on_done_ignored", busy, 1'b0);
        end
        break;
      end
      if (c == busy_at) begin
        start = 1'b1; n_words = 8'd7; cfg_word = ~cfg;
      end else if (c == busy_at + 1) begin
        start = 1'b0; n_words = 8'(n); cfg_word = cfg;
      end
      if (abort_after >= 0 && acc == abort_after && coef_ready) begin
        rst_n = 1'b0;
        #1;
        chk("abort_reg_wr", reg_wr, 1'b0);
        chk("abort_reg_rd", reg_rd, 1'b0);
        chk("abort_reg_addr", reg_addr, 8'd0);
        chk("abort_writedata", reg_writedata, 32'd0);
        chk("abort_coef_ready", coef_ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done_err", {done, err}, 2'b00);
        aborted = 1;
        coef_valid = 1'b0;
        @(negedge clk_2);
        rst_n = 1'b1;
        break;
      end
      if (gap_after >= 0 && acc == gap_after && gap_cnt < gap_len) begin
        coef_valid = 1'b0;
        if (coef_ready) begin
          gap_cnt++;
          if (reg_wr) gap_wr = 1;
        end
      end else if (acc < n) begin
        coef_valid = 1'b1;
        coef_data  = words_q[acc];
      end else begin
        coef_valid = 1'b0;
      end
      if (coef_valid && coef_ready) acc++;
      @(negedge clk_2);
      c++;
    end
    coef_valid = 1'b0;
    if (c >= 4000) begin
      checks++; errors++;
      $display("FAIL load_timeout got=%0d cycles exp=<4000", c);
    end
    if (gap_len > 0 && gap_after >= 0 && gap_after < n && !aborted)
      chk("gap_reg_wr_low", gap_wr, 1'b0);
  endtask

  task automatic check_load(input string tag, input int lat, input int exp_lat,
                            input bit exp_err, input logic [20:0] cfg);
    chk({tag, "_txn_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_txn%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_err"}, err, exp_err);
    if (!exp_err) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_ctrl_word"}, mem[255], {11'd0, cfg});
    end else begin
      chk({tag, "_bypass_kept"}, mem[255][20], 1'b1);
      chk({tag, "_no_done"}, lat, -1);
    end
  endtask

  task automatic fill_words(input int n, input bit seq);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(seq ? 32'(i + 1) : 32'($urandom));
  endtask

  // ---------------- stimulus table ------------------------------------------
  typedef struct {
    int          n;
    bit          seq;
    logic [20:0] cfg;
    int          gap_after;
    int          gap_len;
    int          caddr;
    int          busy_at;
    bit          sod;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  lat;
    bit  aborted;
    bit  merr;
    int  n;
    int  ga;
    int  gl;
    int  ca;
    logic [20:0] cfg;

    vecs[0] = '{4,   1, 21'h092001, -1, 0, -1, -1, 0, 27,   0};
    vecs[1] = '{0,   1, 21'h0abcde, -1, 0, -1, -1, 0, 6,    0};
    vecs[2] = '{4,   1, 21'h092001,  2, 5, -1, -1, 0, 32,   0};
    vecs[3] = '{4,   1, 21'h092001, -1, 0,  2, -1, 0, -1,   1};
    vecs[4] = '{6,   0, 21'h13c4a5, -1, 0, -1,  8, 0, 37,   0};
    vecs[5] = '{1,   0, 21'h054321, -1, 0, -1, -1, 1, 12,   0};
    vecs[6] = '{255, 0, 21'h1f0f0f, -1, 0, -1, -1, 0, 1282, 0};

    // reset state
    repeat (3) @(negedge clk_2);
    chk("rst_wr_rd", {reg_wr, reg_rd}, 2'b00);
    chk("rst_addr", reg_addr, 8'd0);
    chk("rst_writedata", reg_writedata, 32'd0);
    chk("rst_status", {coef_ready, busy, done, err}, 4'b0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_2);

    foreach (vecs[v]) begin
      fill_words(vecs[v].n, vecs[v].seq);
      corrupt_addr = vecs[v].caddr;
      model(vecs[v].n, vecs[v].cfg, vecs[v].caddr, merr);
      chk($sformatf("vec%0d_model_err", v), merr, vecs[v].exp_err);
      run_load(vecs[v].n, vecs[v].cfg, vecs[v].gap_after, vecs[v].gap_len,
               vecs[v].busy_at, -1, vecs[v].sod, lat, aborted);
      check_load($sformatf("vec%0d", v), lat, vecs[v].exp_lat, vecs[v].exp_err, vecs[v].cfg);
      $display("vec%0d n=%0d cfg=%06h latency=%0d err=%0b", v, vecs[v].n, vecs[v].cfg, lat, err);
      corrupt_addr = -1;
      if (vecs[v].exp_err) begin
        repeat (3) @(negedge clk_2);
        chk("err_sticky", err, 1'b1);
      end
      repeat (2) @(negedge clk_2);
    end

    // reset pulsed mid-stream, then a clean full load
    fill_words(5, 0);
    run_load(5, 21'h0a5a5a, -1, 0, -1, 2, 0, lat, aborted);
    chk("abort_happened", aborted, 1'b1);
    $display("abort load: reset asserted during COEF_WR");
    repeat (2) @(negedge clk_2);
    model(5, 21'h0a5a5a, -1, merr);
    run_load(5, 21'h0a5a5a, -1, 0, -1, -1, 0, lat, aborted);
    check_load("after_abort", lat, model_latency(5, -1, 0), merr, 21'h0a5a5a);
    $display("after_abort n=5 latency=%0d err=%0b", lat, err);
    repeat (2) @(negedge clk_2);

    // randomized loads against the model
    for (int r = 0; r < 12; r++) begin
      n   = $urandom_range(0, 24);
      cfg = 21'($urandom);
      ga  = -1; gl = 0; ca = -1;
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        ga = $urandom_range(0, n - 1);
        gl = $urandom_range(1, 6);
      end
      if (n > 0 && $urandom_range(0, 3) == 0) ca = $urandom_range(0, n - 1);
      fill_words(n, 0);
      corrupt_addr = ca;
      model(n, cfg, ca, merr);
      run_load(n, cfg, ga, gl, -1, -1, 0, lat, aborted);
      check_load($sformatf("rnd%0d", r), lat, model_latency(n, ga, gl), merr, cfg);
      $display("rnd%0d n=%0d cfg=%06h gap=%0d/%0d corrupt=%0d latency=%0d err=%0b",
               r, n, cfg, ga, gl, ca, lat, err);
      corrupt_addr = -1;
      repeat (2) @(negedge clk_2);
    end

    chk("strobes_exclusive", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
